// File: rtl/counter_ctl.sv
// Run-time configurable up/down counter with prescaler, one-shot/loop modes,
// a one-cycle terminal-count pulse and a sticky done flag.
module counter_ctl #(
   parameter int WIDTH        = 8,
   parameter int PRESCALE_DIV = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_start,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dir,
   input  logic             i_loop,
   input  logic [WIDTH-1:0] i_max,
   output logic [WIDTH-1:0] o_cnt_val,
   output logic             o_tc,
   output logic             o_done,
   output logic             o_busy
);

   localparam int PS_W = ($clog2(PRESCALE_DIV) > 0) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] cnt_r;
   logic [PS_W-1:0]  ps_r;
   logic             tc_r;
   logic             busy_r;
   logic             done_r;

   logic             ps_last_s;
   logic             term_s;

   // Prescaler wrap point and terminal test on the pre-update count
   always_comb begin
      ps_last_s = (ps_r == PS_LAST);
      if (i_dir) begin
         term_s = (cnt_r == i_max);
      end else begin
         term_s = (cnt_r == {WIDTH{1'b0}});
      end
   end

   // Control FSM, prescaler and count register with registered status outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {WIDTH{1'b0}};
         ps_r    <= {PS_W{1'b0}};
         tc_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (i_clr) begin
         state_r <= IDLE;
         cnt_r   <= {WIDTH{1'b0}};
         ps_r    <= {PS_W{1'b0}};
         tc_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (i_start) begin
         state_r <= RUN;
         cnt_r   <= i_dir ? {WIDTH{1'b0}} : i_max;
         ps_r    <= {PS_W{1'b0}};
         tc_r    <= 1'b0;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else if (i_load) begin
         cnt_r <= i_load_val;
         ps_r  <= {PS_W{1'b0}};
         tc_r  <= 1'b0;
      end else if ((state_r == RUN) && i_en) begin
         if (ps_last_s) begin
            ps_r <= {PS_W{1'b0}};
            if (term_s) begin
               tc_r <= 1'b1;
               if (i_loop) begin
                  cnt_r <= i_dir ? {WIDTH{1'b0}} : i_max;
               end else begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end else begin
               tc_r  <= 1'b0;
               cnt_r <= i_dir ? (cnt_r + WIDTH'(1)) : (cnt_r - WIDTH'(1));
            end
         end else begin
            ps_r <= ps_r + PS_W'(1);
            tc_r <= 1'b0;
         end
      end else begin
         tc_r <= 1'b0;
      end
   end

   assign o_cnt_val = cnt_r;
   assign o_tc      = tc_r;
   assign o_done    = done_r;
   assign o_busy    = busy_r;

endmodule

// File: doc/counter_ctl.md
Name: counter_ctl

Overview:
Parametrised, run-time-configurable counter for timers, tick generation and event sequencing. Counts up or down between 0 and a run-time terminal value, with a programmable prescaler and one-shot or loop mode. Supports start/clear/load control and gives a single-cycle terminal-count pulse plus a sticky done flag. Instantiated wherever a fixed-limit free-running counter is insufficient.

Parameters:
WIDTH, 8, bit width of count value, terminal value and load value (>=1)
PRESCALE_DIV, 1, enabled i_clk cycles per count tick (>=1); 1 = tick every enabled cycle
PS_W, $clog2(PRESCALE_DIV)>0 ? $clog2(PRESCALE_DIV) : 1, prescaler width (localparam)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_en  in  1  count enable; gates the prescaler and ticks
i_clr  in  1  synchronous clear to IDLE
i_start  in  1  arm/restart a count run
i_load  in  1  synchronous load of count value
i_load_val  in  WIDTH  value written on i_load
i_dir  in  1  1 = count up, 0 = count down
i_loop  in  1  1 = reload on terminal, 0 = one-shot
i_max  in  WIDTH  terminal value (up) / reload value (down)
o_cnt_val  out  WIDTH  current count
o_tc  out  1  one-cycle terminal-count pulse, registered
o_done  out  1  sticky: one-shot run completed
o_busy  out  1  high in RUN state

Behaviour:
- Reset (i_rst_n=0, async): cnt=0, prescaler=0, state=IDLE, o_tc=0, o_done=0, o_busy=0.
- States: IDLE, RUN, DONE. o_busy = (state==RUN). o_done = (state==DONE).
- Priority per edge: reset > i_clr > i_start > i_load > tick.
- i_clr: cnt=0, prescaler=0, state=IDLE, o_tc=0.
- i_start, from any state: state=RUN, prescaler=0, cnt = 0 if i_dir=1, else i_max. A start during RUN restarts the run. i_load in the same cycle is ignored.
- i_load without start/clr: cnt=i_load_val, prescaler=0, state unchanged.
- Tick: state==RUN and i_en=1 and prescaler==PRESCALE_DIV-1.
  - Prescaler increments on each RUN and i_en cycle and wraps to 0 on a tick.
  - i_en=0 freezes both prescaler and cnt.
- Terminal check is evaluated at the tick, on the pre-update cnt and the current i_dir:
  - up: terminal when cnt==i_max
  - down: terminal when cnt==0
- On a non-terminal tick: cnt ± 1, arithmetic modulo 2^WIDTH.
  - An up count with cnt>i_max wraps through 2^WIDTH-1 to 0 and continues until it reaches i_max.
- On a terminal tick:
  - o_tc=1 for exactly the next cycle.
  - If i_loop=1: cnt = 0 (up) or i_max (down); stay in RUN.
  - If i_loop=0: cnt holds its value; state=DONE.
- o_tc=0 on every cycle that does not follow a terminal tick.
- Latency: the tick edge updates cnt and asserts o_tc at the same edge, so both are visible in the following cycle.
- i_max==0: every tick is terminal. cnt stays 0 and o_tc pulses every tick in loop mode.
- i_dir, i_max and i_loop are sampled live at each tick. Changes mid-run take effect at the next tick and do not reload cnt.
- DONE holds cnt until i_start, i_clr or reset. Ticks are ignored in IDLE and DONE.
- Reset asserted mid-run: immediate return to reset values. Counting resumes only after i_start.

Test Plan:
- Reset/idle: WIDTH=8, PRESCALE_DIV=1. Assert i_rst_n=0 mid-run → all outputs 0 asynchronously. Release with i_en=1 and no start → cnt stays 0, o_busy=0.
- Up loop: i_max=5, i_dir=1, i_loop=1, i_start pulse, i_en=1 → cnt 0,1,2,3,4,5,0,1...; o_tc high one cycle after each 5→0 transition edge, every 6 cycles.
- Down one-shot with prescale: PRESCALE_DIV=3, i_max=2, i_dir=0, i_loop=0 → cnt 2→1→0, one step per 3 cycles. Then one o_tc pulse after a further 3 cycles, o_done=1, o_busy=0, cnt holds 0; a subsequent i_start reloads 2 and clears o_done.
- Enable gating: i_en toggled 1,0,0,1 during RUN with PRESCALE_DIV=2 → prescaler and cnt frozen while i_en=0; tick spacing counts only enabled cycles.
- Load/priority: during RUN up to i_max=10, i_load with i_load_val=8 → cnt=8, then 9, 10, o_tc. i_start+i_load in the same cycle → cnt=0 (start wins). i_clr+i_start → IDLE, cnt=0.
- Boundaries: i_max=0 loop → o_tc every tick. Load 0xFE with i_max=3, up → cnt FE, FF, 00...03, then o_tc. Flip i_dir mid-run → direction reverses at the next tick with no reload.
